// File: rtl/mult_share_arb_pkg.sv
// rtl/mult_share_arb_pkg.sv - widths, defaults, lock states and one-hot decode for mult_share_arb
package mult_share_arb_pkg;

  localparam int OPW          = 16;
  localparam int PRODW        = 32;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_MULT_LAT = 1;
  localparam int MAX_REQ      = 8;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_state_t;

  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mult16x16.sv
// rtl/mult16x16.sv - registered-input 16x16 signed multiplier, one clock from operands to product
module mult16x16
  import mult_share_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] dout
);

  logic signed [OPW-1:0]   a_r;
  logic signed [OPW-1:0]   b_r;
  logic signed [PRODW-1:0] prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
    end else if (ce) begin
      a_r <= a;
      b_r <= b;
    end
  end

  assign prod = a_r * b_r;
  assign dout = prod;

endmodule

// File: rtl/mult_share_arb_rr_arbiter.sv
// rtl/mult_share_arb_rr_arbiter.sv - round-robin pick: first valid at or above ptr, wrapping
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] back;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   pick;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign dbl   = {valid, valid} >> ptr;
  assign rot   = dbl[NREQ-1:0];
  assign pick  = rot & (~rot + NREQ'(1));
  assign back  = {pick, pick} << ptr;
  assign grant = back[2*NREQ-1:NREQ];

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - shares one 16x16 signed multiplier among NREQ requesters, round-robin
// Optional requester locking when MULT_ARB_LOCK_EN is defined.
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int MULT_LAT = DEF_MULT_LAT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
`ifdef MULT_ARB_LOCK_EN
  input  logic [NREQ-1:0]     req_lock,
`endif
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [PRODW-1:0]    rsp_data,
  output logic [OPW-1:0]      mult_a,
  output logic [OPW-1:0]      mult_b,
  output logic                mult_ce,
  output logic                mult_reset,
  input  logic [PRODW-1:0]    mult_dout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      rst_sync;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] arb_valid;
  logic [NREQ-1:0] rr_grant;
  logic [NREQ-1:0] grant;
  logic [2:0]      gidx;
  logic [2:0]      gnext;
  logic [NREQ-1:0] tag [MULT_LAT];

  // Multiplier reset is held for two edges after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b11;
    else          rst_sync <= {rst_sync[0], 1'b0};
  end
  assign mult_reset = rst_sync[1];

  assign arb_valid = req_valid & {NREQ{~mult_reset}};

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .valid (arb_valid),
    .ptr   (ptr),
    .grant (rr_grant)
  );

`ifdef MULT_ARB_LOCK_EN
  lock_state_t     state;
  lock_state_t     state_nxt;
  logic [2:0]      owner;
  logic [2:0]      owner_nxt;
  logic [NREQ-1:0] own_oh;

  assign own_oh = NREQ'(1) << owner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    grant     = rr_grant;
    case (state)
      ST_IDLE: begin
        if (|(rr_grant & req_lock)) begin
          state_nxt = ST_LOCKED;
          owner_nxt = onehot2idx(MAX_REQ'(rr_grant));
        end
      end
      ST_LOCKED: begin
        grant = arb_valid & own_oh;
        if (!(|(req_lock & own_oh))) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
`else
  assign grant = rr_grant;
`endif

  assign req_ready = grant;
  assign mult_ce   = |grant;
  assign gidx      = onehot2idx(MAX_REQ'(grant));
  assign gnext     = (gidx == 3'(NREQ-1)) ? 3'd0 : gidx + 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   ptr <= '0;
    else if (|grant) ptr <= PW'(gnext);
  end

  always_comb begin
    mult_a = '0;
    mult_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mult_a = req_a[OPW*i +: OPW];
        mult_b = req_b[OPW*i +: OPW];
      end
    end
  end

  // Grant tag travels alongside the product; rsp_valid is the final stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < MULT_LAT; s++) tag[s] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      tag[0] <= grant;
      for (int s = 1; s < MULT_LAT; s++) tag[s] <= tag[s-1];
      rsp_valid <= tag[MULT_LAT-1];
      if (|tag[MULT_LAT-1]) rsp_data <= mult_dout;
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - self-checking bench for mult_share_arb with a scoreboard reference model
module tb_mult_share_arb;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*16-1:0] req_a = '0;
  logic [NREQ*16-1:0] req_b = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_data;
  logic [15:0]       mult_a;
  logic [15:0]       mult_b;
  logic              mult_ce;
  logic              mult_reset;
  logic [31:0]       mult_dout;

  always #5 clk = ~clk;

  mult_share_arb #(.NREQ(NREQ), .MULT_LAT(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
`ifdef MULT_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_ce    (mult_ce),
    .mult_reset (mult_reset),
    .mult_dout  (mult_dout)
  );

  mult16x16 u_mul (
    .clk   (clk),
    .reset (mult_reset),
    .ce    (mult_ce),
    .a     (mult_a),
    .b     (mult_b),
    .dout  (mult_dout)
  );

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] prod;
  } exp_t;

  typedef struct {
    int          req;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rel_edges = 0;
  int          ptr = 0;
  int          owner = -1;
  logic [31:0] last = '0;
  vec_t        tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int model_pick();
    if (rel_edges < 2) return -1;
    if (owner >= 0) return req_valid[owner] ? owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      int j = (ptr + k) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic do_reset(input int ncyc);
    reset_n = 1'b0;
    q.delete();
    ptr = 0;
    owner = -1;
    last = '0;
    rel_edges = 0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mult_ce", mult_ce, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_mult_reset", mult_reset, 1);
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Inputs are already set at the negedge; check, advance one clock, check responses.
  task automatic cycle();
    int g;
    logic signed [15:0] a, b;
    exp_t e;
    #1;
    chk("mult_reset", mult_reset, rel_edges < 2);
    g = model_pick();
    chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("mult_ce", mult_ce, g >= 0);
    if (g >= 0) begin
      a = req_a[16*g +: 16];
      b = req_b[16*g +: 16];
      chk("mult_a", mult_a, $unsigned(a));
      chk("mult_b", mult_b, $unsigned(b));
      e.due  = cyc + 2;
      e.idx  = g;
      e.prod = a * b;
      q.push_back(e);
      ptr = (g + 1) % NREQ;
    end
`ifdef MULT_ARB_LOCK_EN
    if (owner < 0) begin
      if (g >= 0 && req_lock[g]) owner = g;
    end else if (!req_lock[owner]) begin
      owner = -1;
    end
`endif
    @(posedge clk);
    cyc++;
    if (reset_n && rel_edges < 2) rel_edges++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", rsp_valid, 64'd1 << e.idx);
      chk("rsp_data", rsp_data, e.prod);
      last = e.prod;
    end else begin
      chk("rsp_valid_idle", rsp_valid, 0);
      chk("rsp_data_hold", rsp_data, last);
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{2, 16'h7FFF, 16'h0002, 32'h0000_FFFE};
    tbl[1] = '{0, 16'h8000, 16'h8000, 32'h4000_0000};
    tbl[2] = '{1, 16'h8000, 16'h7FFF, 32'hC000_8000};
    tbl[3] = '{3, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
    tbl[4] = '{0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    tbl[5] = '{2, 16'h0000, 16'h1234, 32'h0000_0000};

    @(negedge clk);
    // Reset release with everyone requesting: nothing until mult_reset drops, then 0,1,2,3,0.
    req_valid = 4'hF;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    do_reset(2);
    repeat (7) cycle();
    req_valid = '0;
    repeat (2) cycle();

    // Single-requester vectors and the signed corners.
    foreach (tbl[t]) begin
      req_valid = 4'(1 << tbl[t].req);
      req_a[16*tbl[t].req +: 16] = tbl[t].a;
      req_b[16*tbl[t].req +: 16] = tbl[t].b;
      cycle();
      req_valid = '0;
      cycle();
      chk("tbl_rsp_valid", rsp_valid, 64'd1 << tbl[t].req);
      chk("tbl_rsp_data", rsp_data, tbl[t].p);
      cycle();
    end

    // All four continuously valid, a = i+1, b = -3.
    do_reset(1);
    req_valid = '0;
    repeat (2) cycle();
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'(i + 1);
      req_b[16*i +: 16] = 16'hFFFD;
    end
    req_valid = 4'hF;
    repeat (8) cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Only requester 0: granted every cycle.
    req_valid = 4'b0001;
    repeat (4) cycle();
    req_valid = '0;
    repeat (2) cycle();

    // Reset pulse with products in flight; pointer returns to 0.
    req_valid = 4'b0011;
    repeat (2) cycle();
    do_reset(1);
    req_valid = '0;
    repeat (3) cycle();
    req_valid = 4'hF;
    cycle();
    req_valid = '0;
    repeat (3) cycle();

`ifdef MULT_ARB_LOCK_EN
    // Requester 1 holds the multiplier for three locked ops, then releases.
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    cycle();
    req_valid = 4'b0111;
    repeat (2) cycle();
    req_lock = '0;
    repeat (3) cycle();
    req_valid = '0;
    repeat (3) cycle();
`endif

    // Randomized traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end
      req_valid = 4'($urandom_range(0, 15));
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
      req_lock = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cycle();
    end
    req_valid = '0;
    req_lock  = '0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
